instr_encoder: RTL

// - Encoder counterpart of the control-unit decode path: packs instruction fields (kind, funct3/7,
//   rd/rs1/rs2, imm) into 32-bit RV64 words for the R/I/LD/SD/B subset the pipeline decodes.
// - Buffers the encoded words in a FIFO and writes them into instruction memory at sequential addresses.
// - Used as the program loader / stimulus source ahead of the pipelined core.

---
 rtl/instr_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs R/I/LD/SD/B instruction fields into 32-bit words, queues them in a FIFO
// and streams them into instruction memory at sequential byte addresses.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [15:0]       words_written,
    output logic              err_pulse,
    output logic [1:0]        err_code
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_KIND  = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_ALIGN = 2'd3;

    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       ww_q, ww_d;
    logic              err_pulse_q, err_pulse_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [31:0] enc_word;
    logic [1:0]  enc_err;
    logic        is_shift, accept, push, pop;

    // Field packing and legality checks, purely from the current inputs.
    always_comb begin
        enc_word = '0;
        enc_err  = ERR_NONE;
        is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
        case (in_kind)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: begin
                if (is_shift) begin
                    enc_word = {in_funct7[6:1], in_imm[5:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                    if (in_imm[12:6] != '0) enc_err = ERR_RANGE;
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                    if (in_imm[12] != in_imm[11]) enc_err = ERR_RANGE;
                end
            end
            3'd2: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
                if (in_imm[12] != in_imm[11]) enc_err = ERR_RANGE;
            end
            3'd3: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
                if (in_imm[12] != in_imm[11]) enc_err = ERR_RANGE;
            end
            3'd4: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                if (in_imm[0]) enc_err = ERR_ALIGN;
            end
            default: enc_err = ERR_KIND;
        endcase
    end

    // Space is judged on current occupancy only, so a same-cycle pop never frees a slot.
    assign in_ready = (cnt_q != CNT_W'(DEPTH)) && !clear;
    assign accept   = in_valid && in_ready;
    assign push     = accept && (enc_err == ERR_NONE);
    assign pop      = imem_we && imem_ready && !clear;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        ww_d        = ww_q;
        err_pulse_d = accept && (enc_err != ERR_NONE);
        err_code_d  = err_pulse_d ? enc_err : err_code_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            addr_d   = ADDR_W'(BASE_ADDR);
            ww_d     = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                addr_d   = addr_q + ADDR_W'(4);
                if (ww_q != 16'hFFFF) ww_d = ww_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            addr_q      <= ADDR_W'(BASE_ADDR);
            ww_q        <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            if (push) mem_q[wr_ptr_q] <= enc_word;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            ww_q        <= ww_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end

    assign imem_we       = (cnt_q != '0);
    assign imem_addr     = addr_q;
    assign imem_wdata    = mem_q[rd_ptr_q];
    assign words_written = ww_q;
    assign err_pulse     = err_pulse_q;
    assign err_code      = err_code_q;
endmodule
